// File: rtl/dc_motor_pkg.sv
// Shared encodings for the multi-channel H-bridge PWM motor driver.
// Build option: DC_MOTOR_RAMP_EN enables the soft-start duty ramp.
package dc_motor_pkg;

  // Requested channel mode, shared by the manual and coordinate request paths
  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_FWD   = 2'b01;
  localparam logic [1:0] MODE_REV   = 2'b10;
  localparam logic [1:0] MODE_BRAKE = 2'b11;

  // Per-channel bridge state
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_FWD = 3'd1,
    ST_RUN_REV = 3'd2,
    ST_DEAD    = 3'd3,
    ST_BRAKE   = 3'd4
  } state_e;

  // All-ones duty; users slice the low PWM_W bits for 100% drive
  localparam logic [31:0] DUTY_FULL = '1;

endpackage

// File: rtl/dc_motor_channel.sv
// One H-bridge channel: mode FSM, reversal dead interval, duty ramp and
// registered bridge pins. The PWM counter is shared and comes from the top.
// Build option: DC_MOTOR_RAMP_EN selects stepped soft-start; otherwise the
// running duty jumps straight to the target.
module dc_motor_channel
  import dc_motor_pkg::*;
#(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned DEAD_CYC = 1000,
  parameter int unsigned RAMP_DIV = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic [1:0]       tgt_mode,
  input  logic [PWM_W-1:0] tgt_duty,
  output logic             pin1,
  output logic             pin2,
  output logic             busy
);

  localparam int unsigned      DEAD_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);
  localparam logic [PWM_W-1:0]  FULL      = DUTY_FULL[PWM_W-1:0];

  state_e             state_q, state_d;
  logic [PWM_W-1:0]   cur_q, cur_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;
  logic               pin1_q, pin1_d;
  logic               pin2_q, pin2_d;
  logic               busy_q, busy_d;
  logic               drive;

`ifdef DC_MOTOR_RAMP_EN
  localparam int unsigned       RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  logic [RAMP_W-1:0] ramp_q, ramp_d;
`endif

  // Next state, running duty, dead counter and ramp timer
  always_comb begin
    state_e dir_st;
    state_d = state_q;
    cur_d   = cur_q;
    dead_d  = dead_q;
    dir_st  = (tgt_mode == MODE_FWD) ? ST_RUN_FWD : ST_RUN_REV;
`ifdef DC_MOTOR_RAMP_EN
    ramp_d  = '0;
`endif
    case (tgt_mode)
      MODE_STOP: begin
        state_d = ST_IDLE;
        cur_d   = '0;
      end
      MODE_BRAKE: begin
        state_d = ST_BRAKE;
        cur_d   = '0;
      end
      default: begin
        case (state_q)
          // The count is not restarted by target changes; exit follows the
          // target direction current at expiry, even if it equals the old one.
          ST_DEAD: begin
            if (dead_q == '0) begin
              state_d = dir_st;
              cur_d   = '0;
            end else begin
              dead_d = dead_q - 1'b1;
            end
          end
          ST_IDLE, ST_BRAKE: begin
            state_d = dir_st;
            cur_d   = '0;
          end
          default: begin
            if (state_q == dir_st) begin
`ifdef DC_MOTOR_RAMP_EN
              if (ramp_q == RAMP_LAST) begin
                if (cur_q < tgt_duty) begin
                  cur_d = cur_q + 1'b1;
                end else if (cur_q > tgt_duty) begin
                  cur_d = cur_q - 1'b1;
                end
              end else begin
                ramp_d = ramp_q + 1'b1;
              end
`else
              cur_d = tgt_duty;
`endif
            end else begin
              state_d = ST_DEAD;
              cur_d   = '0;
              dead_d  = DEAD_LOAD;
            end
          end
        endcase
      end
    endcase
  end

  // Pin and busy decode from the present state and shared counter
  always_comb begin
    drive  = (cur_q == FULL) || (pwm_cnt < cur_q);
    pin1_d = 1'b0;
    pin2_d = 1'b0;
    case (state_q)
      ST_RUN_FWD: pin1_d = drive;
      ST_RUN_REV: pin2_d = drive;
      ST_BRAKE: begin
        pin1_d = 1'b1;
        pin2_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_q == ST_DEAD);
`ifdef DC_MOTOR_RAMP_EN
    if ((state_q == ST_RUN_FWD || state_q == ST_RUN_REV) && cur_q != tgt_duty) begin
      busy_d = 1'b1;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      dead_q  <= '0;
      pin1_q  <= 1'b0;
      pin2_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DC_MOTOR_RAMP_EN
      ramp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dead_q  <= dead_d;
      pin1_q  <= pin1_d;
      pin2_q  <= pin2_d;
      busy_q  <= busy_d;
`ifdef DC_MOTOR_RAMP_EN
      ramp_q  <= ramp_d;
`endif
    end
  end

  assign pin1 = pin1_q;
  assign pin2 = pin2_q;
  assign busy = busy_q;

endmodule

// File: rtl/dc_motor_pwm_controller.sv
// Multi-channel H-bridge PWM motor driver top: shared PWM counter,
// coordinate/manual request select and one dc_motor_channel per motor.
// Build option: DC_MOTOR_RAMP_EN enables the soft-start duty ramp.
module dc_motor_pwm_controller
  import dc_motor_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned DEAD_CYC = 1000,
  parameter int unsigned RAMP_DIV = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       cmd_valid,
  input  logic [2*NUM_CH-1:0]     cmd_mode,
  input  logic [PWM_W*NUM_CH-1:0] cmd_duty,
  input  logic [NUM_CH-1:0]       coord_enable,
  input  logic [2*NUM_CH-1:0]     coord_mode,
  input  logic [PWM_W*NUM_CH-1:0] coord_duty,
  output logic [NUM_CH-1:0]       motor_pin1,
  output logic [NUM_CH-1:0]       motor_pin2,
  output logic [NUM_CH-1:0]       busy
);

  logic [PWM_W-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [2*NUM_CH-1:0]     tgt_mode_q, tgt_mode_d;
  logic [PWM_W*NUM_CH-1:0] tgt_duty_q, tgt_duty_d;

  // Free-running PWM counter, wraps naturally at 2^PWM_W
  always_comb pwm_cnt_d = pwm_cnt_q + 1'b1;

  // Request select: the channels act on this cycle's selection, and the
  // held copy keeps the last target once coord_enable drops.
  always_comb begin
    tgt_mode_d = tgt_mode_q;
    tgt_duty_d = tgt_duty_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (coord_enable[i]) begin
        tgt_mode_d[2*i +: 2]         = coord_mode[2*i +: 2];
        tgt_duty_d[PWM_W*i +: PWM_W] = coord_duty[PWM_W*i +: PWM_W];
      end else if (cmd_valid[i]) begin
        tgt_mode_d[2*i +: 2]         = cmd_mode[2*i +: 2];
        tgt_duty_d[PWM_W*i +: PWM_W] = cmd_duty[PWM_W*i +: PWM_W];
      end
    end
  end

  // Counter and held-target registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      tgt_mode_q <= {NUM_CH{MODE_STOP}};
      tgt_duty_q <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      tgt_mode_q <= tgt_mode_d;
      tgt_duty_q <= tgt_duty_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dc_motor_channel #(
      .PWM_W   (PWM_W),
      .DEAD_CYC(DEAD_CYC),
      .RAMP_DIV(RAMP_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt_q),
      .tgt_mode(tgt_mode_d[2*g +: 2]),
      .tgt_duty(tgt_duty_d[PWM_W*g +: PWM_W]),
      .pin1    (motor_pin1[g]),
      .pin2    (motor_pin2[g]),
      .busy    (busy[g])
    );
  end

endmodule
